// File: rtl/sha256_msg_padder_pkg.sv
// Shared types and constants for the SHA-256 message padder.
// Holds the padder state enum, block/length sizes and the pad word.
package sha256_pkg;

  localparam int SHA_BLK_WORDS = 16;
  localparam int SHA_LEN_W = 64;
  localparam logic [31:0] PAD_ONE_WORD = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    ONE,
    ZERO,
    LEN_HI,
    LEN_LO
  } state_t;

  function automatic logic [SHA_LEN_W-1:0] byte_bits(
    input logic [2:0] nb
  );
    return SHA_LEN_W'(nb) << 3;
  endfunction

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Message-in / padded-word-out stream bundle for the padder.
// slave: padder side; master: producer/consumer side.
interface sha256_msg_padder_if;
  import sha256_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_data;
  logic                 in_last;
  logic [2:0]           in_nbytes;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_data;
  logic                 out_blk_last;
  logic                 out_msg_last;
  logic [SHA_LEN_W-1:0] len_o;
  logic                 len_valid;
  logic                 err_o;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    input  in_last,
    input  in_nbytes,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_blk_last,
    output out_msg_last,
    output len_o,
    output len_valid,
    output err_o
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    output in_last,
    output in_nbytes,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_blk_last,
    input  out_msg_last,
    input  len_o,
    input  len_valid,
    input  err_o
  );

endinterface

// File: rtl/sha256_msg_padder_pad_mask.sv
// Final-word masker: keeps nbytes leading bytes, inserts 0x80, zeroes rest.
// Ports: data (word), nbytes (0..4, >=4 passes data through), word (result).
module sha256_pad_mask
  import sha256_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  nbytes,
  output logic [31:0] word
);

  always_comb begin
    word = data;
    unique case (1'b1)
      (nbytes == 3'd0): word = PAD_ONE_WORD;
      (nbytes == 3'd1): word = {data[31:24], 8'h80, 16'h0};
      (nbytes == 3'd2): word = {data[31:16], 8'h80, 8'h0};
      (nbytes == 3'd3): word = {data[31:8], 8'h80};
      default:          word = data;
    endcase
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 padder: message words in, 512-bit padded blocks out.
// Ports: CLK, RST (async, active-low), bus (slave stream bundle).
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int BLK_WORDS = SHA_BLK_WORDS,
  parameter int LEN_W = SHA_LEN_W
) (
  input logic CLK,
  input logic RST,
  sha256_msg_padder_if.slave bus
);

  localparam int IW = $clog2(BLK_WORDS);

  state_t               state;
  state_t               pad_next;
  logic [IW-1:0]        widx;
  logic [IW-1:0]        nidx;
  logic [LEN_W-1:0]     cnt;
  logic [LEN_W:0]       sum;
  logic                 emit;
  logic                 can_load;
  logic                 accept;
  logic                 bad;
  logic                 nblk_last;
  logic [2:0]           nb_eff;
  logic [31:0]          masked;
  logic                 out_valid;
  logic [31:0]          out_data;
  logic                 out_blk_last;
  logic                 out_msg_last;
  logic [SHA_LEN_W-1:0] len_q;
  logic                 len_valid;
  logic                 err;

  assign emit     = out_valid && bus.out_ready;
  assign can_load = !out_valid || bus.out_ready;
  assign accept   = bus.in_valid && bus.in_ready;

  assign bus.in_ready     = (state == DATA) && can_load;
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = out_data;
  assign bus.out_blk_last = out_blk_last;
  assign bus.out_msg_last = out_msg_last;
  assign bus.len_o        = len_q;
  assign bus.len_valid    = len_valid;
  assign bus.err_o        = err;

  // Malformed byte counts are counted and passed as full words.
  assign bad = (bus.in_nbytes > 3'd4) ||
               (!bus.in_last && bus.in_nbytes != 3'd4);
  assign nb_eff = bad ? 3'd4 : bus.in_nbytes;

  assign sum = {1'b0, cnt} + {1'b0, byte_bits(nb_eff)};

  // Index of the word being loaded into the output register.
  assign nidx      = emit ? widx + IW'(1) : widx;
  assign nblk_last = (nidx == IW'(BLK_WORDS - 1));

  // Length goes in the last two slots, so padding stops at slot 13.
  assign pad_next = (nidx == IW'(BLK_WORDS - 3)) ? LEN_HI : ZERO;

  sha256_pad_mask u_mask (
    .data   (bus.in_data),
    .nbytes (nb_eff),
    .word   (masked)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      widx         <= '0;
      cnt          <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_blk_last <= 1'b0;
      out_msg_last <= 1'b0;
      len_q        <= '0;
      len_valid    <= 1'b0;
      err          <= 1'b0;
    end else begin
      len_valid <= 1'b0;
      if (emit) begin
        widx      <= nidx;
        out_valid <= 1'b0;
      end
      unique case (state)
        IDLE: state <= DATA;
        DATA: begin
          if (accept) begin
            out_valid    <= 1'b1;
            out_data     <= masked;
            out_blk_last <= nblk_last;
            out_msg_last <= 1'b0;
            if (bad || sum[LEN_W]) err <= 1'b1;
            if (bus.in_last) begin
              cnt       <= '0;
              len_q     <= sum[LEN_W-1:0];
              len_valid <= 1'b1;
              state     <= (nb_eff == 3'd4) ? ONE : pad_next;
            end else begin
              cnt <= sum[LEN_W-1:0];
            end
          end
        end
        ONE: begin
          if (can_load) begin
            out_valid    <= 1'b1;
            out_data     <= PAD_ONE_WORD;
            out_blk_last <= nblk_last;
            out_msg_last <= 1'b0;
            state        <= pad_next;
          end
        end
        ZERO: begin
          if (can_load) begin
            out_valid    <= 1'b1;
            out_data     <= '0;
            out_blk_last <= nblk_last;
            out_msg_last <= 1'b0;
            state        <= pad_next;
          end
        end
        LEN_HI: begin
          if (can_load) begin
            out_valid    <= 1'b1;
            out_data     <= len_q[63:32];
            out_blk_last <= nblk_last;
            out_msg_last <= 1'b0;
            state        <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (can_load) begin
            out_valid    <= 1'b1;
            out_data     <= len_q[31:0];
            out_blk_last <= nblk_last;
            out_msg_last <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder.
// Streams known messages and compares padded words and lengths.
module tb_sha256_msg_padder;
  import sha256_pkg::*;

  typedef struct {
    logic [31:0] d;
    logic        bl;
    logic        ml;
  } ow_t;

  logic clk = 1'b0;
  logic RST = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   rnd_ready = 1'b0;

  ow_t         q[$];
  logic [63:0] lq[$];
  logic [31:0] exp[$];

  always #5 clk = ~clk;

  sha256_msg_padder_if bus();

  sha256_msg_padder dut (
    .CLK (clk),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (RST && bus.out_valid && bus.out_ready)
      q.push_back('{bus.out_data, bus.out_blk_last, bus.out_msg_last});
    if (RST && bus.len_valid)
      lq.push_back(bus.len_o);
  end

  task automatic clear_all();
    q.delete();
    lq.delete();
    exp.delete();
  endtask

  task automatic exp_tail(input logic [63:0] len);
    while (exp.size() % 16 != 14) exp.push_back(32'h0);
    exp.push_back(len[63:32]);
    exp.push_back(len[31:0]);
  endtask

  task automatic send_word(
    input logic [31:0] d,
    input logic [2:0]  nb,
    input logic        last
  );
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_nbytes = nb;
    bus.in_last = last;
    @(negedge clk);
    while (!bus.in_ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (n >= 500) begin
      checks++;
      failures++;
      $display("FAIL send_timeout in_ready=%0b required=1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int k;
    k = 0;
    while (q.size() < n && k < 1000) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_nbytes = '0;
    bus.in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_blk_last,
         bus.out_msg_last, bus.len_valid, bus.err_o} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b required=000000",
               {bus.out_valid, bus.in_ready, bus.out_blk_last,
                bus.out_msg_last, bus.len_valid, bus.err_o});
    end
    checks++;
    if (bus.out_data !== 32'h0 || bus.len_o !== 64'h0) begin
      failures++;
      $display("FAIL reset_data out=%h len=%h required=0",
               bus.out_data, bus.len_o);
    end
    #3 RST = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got=%b required=1", bus.in_ready);
    end
  endtask

  task automatic test_empty();
    clear_all();
    send_word(32'h0, 3'd0, 1'b1);
    exp.push_back(32'h8000_0000);
    exp_tail(64'd0);
    wait_done(exp.size());
    checks++;
    if (q.size() != exp.size()) begin
      failures++;
      $display("FAIL empty_count got=%0d required=%0d", q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < q.size(); i++) begin
      checks++;
      if (q[i].d !== exp[i] || q[i].bl !== (i % 16 == 15) ||
          q[i].ml !== (i == exp.size() - 1)) begin
        failures++;
        $display("FAIL empty_w%0d got=%h/%b/%b required=%h/%b/%b", i,
                 q[i].d, q[i].bl, q[i].ml, exp[i], (i % 16 == 15),
                 (i == exp.size() - 1));
      end
    end
    checks++;
    if (lq.size() != 1 || lq[0] !== 64'd0) begin
      failures++;
      $display("FAIL empty_len pulses=%0d required=1 len=0", lq.size());
    end
  endtask

  task automatic test_abc();
    clear_all();
    send_word(32'h6162_6300, 3'd3, 1'b1);
    exp.push_back(32'h6162_6380);
    exp_tail(64'd24);
    wait_done(exp.size());
    checks++;
    if (q.size() != exp.size()) begin
      failures++;
      $display("FAIL abc_count got=%0d required=%0d", q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < q.size(); i++) begin
      checks++;
      if (q[i].d !== exp[i] || q[i].bl !== (i % 16 == 15) ||
          q[i].ml !== (i == exp.size() - 1)) begin
        failures++;
        $display("FAIL abc_w%0d got=%h/%b/%b required=%h", i,
                 q[i].d, q[i].bl, q[i].ml, exp[i]);
      end
    end
    checks++;
    if (lq.size() != 1 || lq[0] !== 64'd24) begin
      failures++;
      $display("FAIL abc_len got=%h pulses=%0d required=18",
               bus.len_o, lq.size());
    end
  endtask

  task automatic test_60_bytes();
    clear_all();
    for (int i = 0; i < 15; i++) begin
      send_word(32'h1000_0000 + i, 3'd4, i == 14);
      exp.push_back(32'h1000_0000 + i);
    end
    exp.push_back(32'h8000_0000);
    exp_tail(64'h1E0);
    wait_done(exp.size());
    checks++;
    if (q.size() != 32) begin
      failures++;
      $display("FAIL b60_count got=%0d required=32", q.size());
    end
    for (int i = 0; i < exp.size() && i < q.size(); i++) begin
      checks++;
      if (q[i].d !== exp[i] || q[i].bl !== (i % 16 == 15) ||
          q[i].ml !== (i == exp.size() - 1)) begin
        failures++;
        $display("FAIL b60_w%0d got=%h/%b/%b required=%h", i,
                 q[i].d, q[i].bl, q[i].ml, exp[i]);
      end
    end
    checks++;
    if (lq.size() != 1 || lq[0] !== 64'h1E0) begin
      failures++;
      $display("FAIL b60_len got=%h required=1e0", bus.len_o);
    end
  endtask

  task automatic test_55_bytes();
    clear_all();
    for (int i = 0; i < 13; i++) begin
      send_word(32'h2000_0000 + i, 3'd4, 1'b0);
      exp.push_back(32'h2000_0000 + i);
    end
    send_word(32'hAABB_CCDD, 3'd3, 1'b1);
    exp.push_back(32'hAABB_CC80);
    exp_tail(64'd440);
    wait_done(exp.size());
    checks++;
    if (q.size() != 16) begin
      failures++;
      $display("FAIL b55_count got=%0d required=16", q.size());
    end
    for (int i = 0; i < exp.size() && i < q.size(); i++) begin
      checks++;
      if (q[i].d !== exp[i] || q[i].bl !== (i % 16 == 15) ||
          q[i].ml !== (i == exp.size() - 1)) begin
        failures++;
        $display("FAIL b55_w%0d got=%h/%b/%b required=%h", i,
                 q[i].d, q[i].bl, q[i].ml, exp[i]);
      end
    end
    checks++;
    if (lq.size() != 1 || lq[0] !== 64'd440) begin
      failures++;
      $display("FAIL b55_len got=%h required=1b8", bus.len_o);
    end
  endtask

  task automatic test_stall();
    logic        prev_stall;
    logic [31:0] prev_data;
    int          k;
    clear_all();
    rnd_ready = 1'b1;
    send_word(32'h6162_6300, 3'd3, 1'b1);
    exp.push_back(32'h6162_6380);
    exp_tail(64'd24);
    prev_stall = 1'b0;
    prev_data = '0;
    k = 0;
    while (q.size() < exp.size() && k < 1000) begin
      @(negedge clk);
      k++;
      if (prev_stall) begin
        checks++;
        if (bus.out_data !== prev_data) begin
          failures++;
          $display("FAIL stall_hold got=%h required=%h",
                   bus.out_data, prev_data);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
    end
    rnd_ready = 1'b0;
    wait_done(exp.size());
    checks++;
    if (q.size() != exp.size()) begin
      failures++;
      $display("FAIL stall_count got=%0d required=%0d", q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < q.size(); i++) begin
      checks++;
      if (q[i].d !== exp[i] || q[i].bl !== (i % 16 == 15) ||
          q[i].ml !== (i == exp.size() - 1)) begin
        failures++;
        $display("FAIL stall_w%0d got=%h/%b/%b required=%h", i,
                 q[i].d, q[i].bl, q[i].ml, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_all();
    send_word(32'h6162_6300, 3'd3, 1'b1);
    send_word(32'h0, 3'd0, 1'b1);
    exp.push_back(32'h6162_6380);
    exp_tail(64'd24);
    exp.push_back(32'h8000_0000);
    exp_tail(64'd0);
    wait_done(exp.size());
    checks++;
    if (q.size() != 32) begin
      failures++;
      $display("FAIL b2b_count got=%0d required=32", q.size());
    end
    for (int i = 0; i < exp.size() && i < q.size(); i++) begin
      checks++;
      if (q[i].d !== exp[i] || q[i].bl !== (i % 16 == 15) ||
          q[i].ml !== (i == 15 || i == 31)) begin
        failures++;
        $display("FAIL b2b_w%0d got=%h/%b/%b required=%h", i,
                 q[i].d, q[i].bl, q[i].ml, exp[i]);
      end
    end
    checks++;
    if (lq.size() != 2 || lq[0] !== 64'd24 || lq[1] !== 64'd0) begin
      failures++;
      $display("FAIL b2b_len pulses=%0d required=2 (24,0)", lq.size());
    end
  endtask

  task automatic test_error();
    clear_all();
    checks++;
    if (bus.err_o !== 1'b0) begin
      failures++;
      $display("FAIL err_clean got=%b required=0", bus.err_o);
    end
    send_word(32'h1111_1111, 3'd2, 1'b0);
    checks++;
    if (bus.err_o !== 1'b1) begin
      failures++;
      $display("FAIL err_set got=%b required=1", bus.err_o);
    end
    send_word(32'h2222_2222, 3'd4, 1'b1);
    exp.push_back(32'h1111_1111);
    exp.push_back(32'h2222_2222);
    exp.push_back(32'h8000_0000);
    exp_tail(64'd64);
    wait_done(exp.size());
    checks++;
    if (bus.err_o !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got=%b required=1", bus.err_o);
    end
    checks++;
    if (q.size() != 16) begin
      failures++;
      $display("FAIL err_count got=%0d required=16", q.size());
    end
    for (int i = 0; i < exp.size() && i < q.size(); i++) begin
      checks++;
      if (q[i].d !== exp[i]) begin
        failures++;
        $display("FAIL err_w%0d got=%h required=%h", i, q[i].d, exp[i]);
      end
    end
    checks++;
    if (lq.size() != 1 || lq[0] !== 64'd64) begin
      failures++;
      $display("FAIL err_len got=%h required=40", bus.len_o);
    end
  endtask

  task automatic test_reset_mid();
    clear_all();
    send_word(32'h6162_6300, 3'd3, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    RST = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_blk_last,
         bus.out_msg_last, bus.len_valid, bus.err_o} !== 6'b0) begin
      failures++;
      $display("FAIL midrst_flags got=%b required=000000",
               {bus.out_valid, bus.in_ready, bus.out_blk_last,
                bus.out_msg_last, bus.len_valid, bus.err_o});
    end
    checks++;
    if (bus.out_data !== 32'h0 || bus.len_o !== 64'h0) begin
      failures++;
      $display("FAIL midrst_data out=%h len=%h required=0",
               bus.out_data, bus.len_o);
    end
    repeat (2) @(negedge clk);
    RST = 1'b1;
    @(posedge clk);
    #1;
    clear_all();
    send_word(32'h0, 3'd0, 1'b1);
    exp.push_back(32'h8000_0000);
    exp_tail(64'd0);
    wait_done(exp.size());
    checks++;
    if (q.size() != 16) begin
      failures++;
      $display("FAIL midrst_count got=%0d required=16", q.size());
    end
    for (int i = 0; i < exp.size() && i < q.size(); i++) begin
      checks++;
      if (q[i].d !== exp[i] || q[i].bl !== (i % 16 == 15) ||
          q[i].ml !== (i == 15)) begin
        failures++;
        $display("FAIL midrst_w%0d got=%h/%b/%b required=%h", i,
                 q[i].d, q[i].bl, q[i].ml, exp[i]);
      end
    end
    checks++;
    if (lq.size() != 1 || lq[0] !== 64'd0) begin
      failures++;
      $display("FAIL midrst_len pulses=%0d required=1", lq.size());
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_abc();
    test_60_bytes();
    test_55_bytes();
    test_stall();
    test_back_to_back();
    test_error();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
